// File: rtl/cpu_pkg.sv
// cpu_pkg: types shared between the instruction decoder and flow control.
//   jump_t        - 4-bit jump condition code; codes 9..15 never jump
//   irq_state_t   - interrupt sequencing states used by flow_ctrl
//   jump_taken()  - evaluates a jump condition against the ALU flags
package cpu_pkg;

    typedef enum logic [3:0] {
        J_ALWAYS = 4'd0,
        J_Z      = 4'd1,
        J_NZ     = 4'd2,
        J_S      = 4'd3,
        J_NS     = 4'd4,
        J_O      = 4'd5,
        J_NO     = 4'd6,
        J_CY     = 4'd7,
        J_NCY    = 4'd8
    } jump_t;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_PENDING = 2'd1,
        IRQ_ISR     = 2'd2
    } irq_state_t;

    function automatic logic jump_taken(jump_t cond, logic z, logic s, logic o, logic cy);
        case (cond)
            J_ALWAYS: jump_taken = 1'b1;
            J_Z:      jump_taken = z;
            J_NZ:     jump_taken = ~z;
            J_S:      jump_taken = s;
            J_NS:     jump_taken = ~s;
            J_O:      jump_taken = o;
            J_NO:     jump_taken = ~o;
            J_CY:     jump_taken = cy;
            J_NCY:    jump_taken = ~cy;
            default:  jump_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/flow_ctrl_if.sv
// flow_ctrl_if: control bundle between the core pipeline and flow_ctrl.
//   master - pipeline side: drives stall, jump/call/ret/irq/iret requests,
//            flags and jump target; reads addr, incremented, in_isr, sp, ovf, udf
//   slave  - flow_ctrl side (mirror of master)
interface flow_ctrl_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 8
);
    localparam int SP_W = $clog2(DEPTH + 1);

    logic              stall;
    logic              is_jump;
    jump_t             jump_cond;
    logic              flag_z;
    logic              flag_s;
    logic              flag_o;
    logic              flag_cy;
    logic [ADDR_W-1:0] jump_addr;
    logic              call;
    logic              ret;
    logic              irq;
    logic              iret;

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] incremented;
    logic              in_isr;
    logic [SP_W-1:0]   sp;
    logic              ovf;
    logic              udf;

    modport master (
        output stall, is_jump, jump_cond, flag_z, flag_s, flag_o, flag_cy,
               jump_addr, call, ret, irq, iret,
        input  addr, incremented, in_isr, sp, ovf, udf
    );

    modport slave (
        input  stall, is_jump, jump_cond, flag_z, flag_s, flag_o, flag_cy,
               jump_addr, call, ret, irq, iret,
        output addr, incremented, in_isr, sp, ovf, udf
    );

endinterface

// File: rtl/ret_stack.sv
// ret_stack: LIFO of return addresses.
//   push/pop  - one operation per cycle; push when full and pop when empty
//               are ignored here (the caller flags them)
//   data_in   - value pushed
//   data_out  - current top of stack (undefined when empty)
//   sp        - number of occupied entries, full/empty derived from it
module ret_stack #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 8,
    localparam int SP_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [SP_W-1:0]  sp,
    output logic             full,
    output logic             empty
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SP_W-1:0]  top;

    assign full     = (sp == SP_W'(DEPTH));
    assign empty    = (sp == '0);
    assign top      = sp - SP_W'(1);
    assign data_out = mem[top[IDX_W-1:0]];

    // Storage is deliberately not reset; sp alone defines what is valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[sp[IDX_W-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

endmodule

// File: rtl/flow_ctrl.sv
// flow_ctrl: program address sequencer with return stack and single-level
// interrupt entry.
//   clk, rst - rising-edge clock, asynchronous active-high reset
//   bus      - flow_ctrl_if.slave (requests and flags in; addr,
//              incremented, in_isr, sp, sticky ovf/udf out)
//
// state       | meaning
// ------------+------------------------------------------------------
// IRQ_IDLE    | no interrupt outstanding; irq moves to PENDING
// IRQ_PENDING | irq latched, waiting for a cycle free of flow changes
// IRQ_ISR     | handler running; irq ignored until iret
module flow_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 8,
    parameter int RESET_VEC = 0,
    parameter int IRQ_VEC   = 240
) (
    input  logic         clk,
    input  logic         rst,
    flow_ctrl_if.slave   bus
);
    localparam int SP_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] IRQ_ADDR   = ADDR_W'(IRQ_VEC);

    irq_state_t        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] incremented;
    logic [ADDR_W-1:0] stack_top;
    logic [SP_W-1:0]   sp;
    logic              ovf;
    logic              udf;
    logic              full;
    logic              empty;
    logic              taken;
    logic              pop_req;
    logic              entry;
    logic              push_en;
    logic              pop_en;

    assign incremented = addr + ADDR_W'(1);
    assign taken   = bus.is_jump & jump_taken(bus.jump_cond, bus.flag_z, bus.flag_s,
                                              bus.flag_o, bus.flag_cy);
    assign pop_req = bus.ret | bus.iret;

    // Interrupt entry only slips into a cycle where the instruction itself
    // does not redirect flow, so the pushed incremented address is exact.
    assign entry   = (state == IRQ_PENDING) & ~pop_req & ~bus.call & ~taken;

    // A pop in the same cycle as a call wins; the call is dropped entirely.
    assign push_en = ~bus.stall & ~pop_req & (bus.call | entry);
    assign pop_en  = ~bus.stall & pop_req;

    ret_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk      (clk),
        .rst      (rst),
        .push     (push_en),
        .pop      (pop_en),
        .data_in  (incremented),
        .data_out (stack_top),
        .sp       (sp),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IRQ_IDLE;
            addr  <= RESET_ADDR;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            // irq is latched even while stalled; everything else freezes.
            case (state)
                IRQ_IDLE:    if (bus.irq)                 state <= IRQ_PENDING;
                IRQ_PENDING: if (!bus.stall && entry)     state <= IRQ_ISR;
                IRQ_ISR:     if (!bus.stall && bus.iret)  state <= IRQ_IDLE;
                default:                                  state <= IRQ_IDLE;
            endcase

            if (!bus.stall) begin
                if (pop_req) begin
                    addr <= empty ? incremented : stack_top;
                    if (empty) udf <= 1'b1;
                end else if (bus.call || taken) begin
                    addr <= bus.jump_addr;
                end else if (entry) begin
                    addr <= IRQ_ADDR;
                end else begin
                    addr <= incremented;
                end

                if (push_en && full) ovf <= 1'b1;
            end
        end
    end

    assign bus.addr        = addr;
    assign bus.incremented = incremented;
    assign bus.in_isr      = (state == IRQ_ISR);
    assign bus.sp          = sp;
    assign bus.ovf         = ovf;
    assign bus.udf         = udf;

endmodule

// File: tb/tb_flow_ctrl.sv
// tb_flow_ctrl: directed bench for flow_ctrl with a queue-based reference
// model compared on every falling edge, plus literal spot checks.
module tb_flow_ctrl;
    import cpu_pkg::*;

    localparam int ADDR_W  = 8;
    localparam int DEPTH   = 8;
    localparam int IRQ_VEC = 240;
    localparam int MASK    = (1 << ADDR_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    flow_ctrl_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    flow_ctrl #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .RESET_VEC (0),
        .IRQ_VEC   (IRQ_VEC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: program counter, return stack as a queue, flags.
    int m_addr = 0;
    int m_stk[$];
    bit m_isr  = 0;
    bit m_pend = 0;
    bit m_ovf  = 0;
    bit m_udf  = 0;

    function automatic bit m_cond(int c, bit z, bit s, bit o, bit cy);
        case (c)
            0: return 1'b1;
            1: return z;
            2: return !z;
            3: return s;
            4: return !s;
            5: return o;
            6: return !o;
            7: return cy;
            8: return !cy;
            default: return 1'b0;
        endcase
    endfunction

    task automatic m_push(int v);
        if (m_stk.size() == DEPTH) m_ovf = 1'b1;
        else m_stk.push_back(v);
    endtask

    task automatic model_step();
        bit isr0;
        bit pend0;
        bit tk;
        int nxt;
        isr0  = m_isr;
        pend0 = m_pend;
        if (bus.irq && !isr0) m_pend = 1'b1;
        if (!bus.stall) begin
            tk = bus.is_jump && m_cond(int'(bus.jump_cond), bus.flag_z, bus.flag_s,
                                       bus.flag_o, bus.flag_cy);
            if (bus.ret || bus.iret) begin
                if (m_stk.size() == 0) begin
                    m_udf = 1'b1;
                    nxt = (m_addr + 1) & MASK;
                end else begin
                    nxt = m_stk.pop_back();
                end
                if (bus.iret) m_isr = 1'b0;
            end else if (bus.call || tk) begin
                if (bus.call) m_push((m_addr + 1) & MASK);
                nxt = int'(bus.jump_addr);
            end else if (pend0) begin
                m_push((m_addr + 1) & MASK);
                nxt = IRQ_VEC;
                m_isr = 1'b1;
                m_pend = 1'b0;
            end else begin
                nxt = (m_addr + 1) & MASK;
            end
            m_addr = nxt;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_addr = 0;
            m_stk.delete();
            m_isr  = 1'b0;
            m_pend = 1'b0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("addr",        32'(bus.addr),        32'(m_addr));
            check("incremented", 32'(bus.incremented), 32'((m_addr + 1) & MASK));
            check("in_isr",      32'(bus.in_isr),      32'(m_isr));
            check("sp",          32'(bus.sp),          32'(m_stk.size()));
            check("ovf",         32'(bus.ovf),         32'(m_ovf));
            check("udf",         32'(bus.udf),         32'(m_udf));
        end
    end

    // Stimulus helpers: inputs change 2 time units after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        bus.stall     = 1'b0;
        bus.is_jump   = 1'b0;
        bus.jump_cond = J_ALWAYS;
        bus.flag_z    = 1'b0;
        bus.flag_s    = 1'b0;
        bus.flag_o    = 1'b0;
        bus.flag_cy   = 1'b0;
        bus.jump_addr = '0;
        bus.call      = 1'b0;
        bus.ret       = 1'b0;
        bus.irq       = 1'b0;
        bus.iret      = 1'b0;
    endtask

    task automatic jmp(logic [7:0] a);
        clr();
        bus.is_jump = 1'b1;
        bus.jump_addr = a;
        cyc();
        clr();
    endtask

    task automatic call_to(logic [7:0] a);
        clr();
        bus.call = 1'b1;
        bus.jump_addr = a;
        cyc();
        clr();
    endtask

    task automatic ret1();
        clr();
        bus.ret = 1'b1;
        cyc();
        clr();
    endtask

    task automatic iret1();
        clr();
        bus.iret = 1'b1;
        cyc();
        clr();
    endtask

    initial begin
        clr();
        #1 rst = 1'b1;
        #2;
        check("lit_reset_addr", 32'(bus.addr),   32'h00);
        check("lit_reset_sp",   32'(bus.sp),     32'h0);
        check("lit_reset_isr",  32'(bus.in_isr), 32'h0);
        #9 rst = 1'b0;
        cyc();
        check("lit_first_edge", 32'(bus.addr), 32'h01);

        // Condition codes
        jmp(8'h12);
        bus.is_jump = 1'b1; bus.jump_cond = J_NCY; bus.flag_cy = 1'b1; bus.jump_addr = 8'h40;
        cyc();
        check("lit_ncy_cy1", 32'(bus.addr), 32'h13);
        bus.flag_cy = 1'b0;
        cyc();
        check("lit_ncy_cy0", 32'(bus.addr), 32'h40);
        clr();
        bus.is_jump = 1'b1; bus.jump_cond = J_Z; bus.flag_z = 1'b0; bus.jump_addr = 8'h50;
        cyc();
        bus.flag_z = 1'b1;
        cyc();
        check("lit_z_taken", 32'(bus.addr), 32'h50);
        bus.jump_cond = jump_t'(4'd12);
        cyc();
        check("lit_bad_cond", 32'(bus.addr), 32'h51);
        bus.jump_cond = J_ALWAYS; bus.is_jump = 1'b0;
        cyc();
        bus.is_jump = 1'b1; bus.jump_cond = J_S; bus.flag_s = 1'b1; bus.jump_addr = 8'h66;
        cyc();
        bus.jump_cond = J_NO; bus.flag_o = 1'b1; bus.jump_addr = 8'h77;
        cyc();
        clr();

        // Address wrap
        jmp(8'hFF);
        check("lit_inc_wrap", 32'(bus.incremented), 32'h00);
        cyc();
        check("lit_wrap_addr", 32'(bus.addr), 32'h00);
        check("lit_wrap_ovf",  32'(bus.ovf),  32'h0);

        // Nine calls, nine returns
        for (int i = 0; i < 9; i++) call_to(8'h10);
        check("lit_9call_sp",   32'(bus.sp),   32'h8);
        check("lit_9call_ovf",  32'(bus.ovf),  32'h1);
        check("lit_9call_addr", 32'(bus.addr), 32'h10);
        for (int i = 0; i < 8; i++) ret1();
        check("lit_8ret_addr", 32'(bus.addr), 32'h01);
        ret1();
        check("lit_9ret_addr", 32'(bus.addr), 32'h02);
        check("lit_9ret_udf",  32'(bus.udf),  32'h1);
        check("lit_9ret_sp",   32'(bus.sp),   32'h0);

        // call + ret together, then stalled call
        call_to(8'h60);
        bus.call = 1'b1; bus.ret = 1'b1; bus.jump_addr = 8'h70;
        cyc();
        clr();
        check("lit_call_ret", 32'(bus.addr), 32'h03);
        bus.stall = 1'b1; bus.call = 1'b1; bus.jump_addr = 8'h77;
        cyc();
        clr();
        check("lit_stall_hold", 32'(bus.addr), 32'h03);

        // irq with a taken jump in the same cycle
        jmp(8'h05);
        bus.irq = 1'b1; bus.is_jump = 1'b1; bus.jump_addr = 8'h20;
        cyc();
        clr();
        check("lit_irq_jump", 32'(bus.addr), 32'h20);
        cyc();
        check("lit_irq_entry", 32'(bus.addr),   32'hF0);
        check("lit_irq_isr",   32'(bus.in_isr), 32'h1);
        bus.irq = 1'b1;
        cyc();
        clr();
        call_to(8'h80);
        ret1();
        check("lit_ret_keeps_isr", 32'(bus.in_isr), 32'h1);
        iret1();
        check("lit_iret_addr", 32'(bus.addr),   32'h21);
        check("lit_iret_isr",  32'(bus.in_isr), 32'h0);
        cyc();
        check("lit_no_reentry", 32'(bus.addr), 32'h22);

        // irq during stall
        jmp(8'h08);
        bus.stall = 1'b1; bus.irq = 1'b1;
        cyc();
        bus.irq = 1'b0;
        cyc();
        check("lit_stall_irq_hold", 32'(bus.addr), 32'h08);
        bus.stall = 1'b0;
        cyc();
        check("lit_stall_irq_entry", 32'(bus.addr), 32'hF0);
        iret1();
        check("lit_stall_irq_top", 32'(bus.addr), 32'h09);

        // Entry with full stack
        for (int i = 0; i < 8; i++) call_to(8'h10);
        bus.irq = 1'b1;
        cyc();
        clr();
        cyc();
        check("lit_full_entry_addr", 32'(bus.addr), 32'hF0);
        check("lit_full_entry_sp",   32'(bus.sp),   32'h8);

        // Asynchronous reset mid-cycle
        jmp(8'h37);
        check("lit_pre_reset", 32'(bus.addr), 32'h37);
        #1 rst = 1'b1;
        #1;
        check("lit_async_addr", 32'(bus.addr),   32'h00);
        check("lit_async_sp",   32'(bus.sp),     32'h0);
        check("lit_async_ovf",  32'(bus.ovf),    32'h0);
        check("lit_async_udf",  32'(bus.udf),    32'h0);
        check("lit_async_isr",  32'(bus.in_isr), 32'h0);
        #2 rst = 1'b0;
        cyc();
        check("lit_post_reset", 32'(bus.addr), 32'h01);
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flow_ctrl.md
FLOW_CTRL -- requirements
Module: flow_ctrl

Interface
REQ-001 ADDR_W, 8, program address width in bits.
REQ-002 DEPTH, 8, return-stack entries (>=2).
REQ-003 RESET_VEC, 0, address loaded on reset.
REQ-004 IRQ_VEC, 240, interrupt entry address (ADDR_W bits).
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 stall  in  1  hold all state this cycle.
REQ-008 is_jump  in  1  current instruction is a jump.
REQ-009 jump_cond  in  jump_t  jump condition.
REQ-010 flag_z, flag_s, flag_o, flag_cy  in  1 each  ALU flags.
REQ-011 jump_addr  in  ADDR_W  jump/call target.
REQ-012 call  in  1  push return address and jump.
REQ-013 ret  in  1  pop return address and jump to it.
REQ-014 irq  in  1  interrupt request, level or pulse.
REQ-015 iret  in  1  return from interrupt.
REQ-016 addr  out  ADDR_W  current program address.
REQ-017 incremented  out  ADDR_W  addr+1 modulo 2^ADDR_W, combinational.
REQ-018 in_isr  out  1  interrupt handler active.
REQ-019 sp  out  $clog2(DEPTH+1)  occupied stack entries.
REQ-020 ovf, udf  out  1 each  sticky stack overflow / underflow.

Function
REQ-021 Jump taken when is_jump and condition true: ALWAYS, Z, NZ, S, NS, O, NO, CY, NCY per flags; encodings outside that set never jump.
REQ-022 Next-address priority when not stalled: iret/ret (popped value) > call/taken jump (jump_addr) > irq entry (IRQ_VEC) > incremented.
REQ-023 call pushes incremented; ret and iret pop; one-cycle latency, new addr visible the cycle after the event.
REQ-024 call and ret in the same cycle: ret executes, call ignored entirely.
REQ-025 call with sp==DEPTH: push discarded, ovf set, jump still taken, sp unchanged.
REQ-026 ret/iret with sp==0: ovf/udf rule -> udf set, addr takes incremented, sp unchanged, in_isr still cleared by iret.
REQ-027 irq assertion (while not in_isr) sets an internal pending latch that holds until entry; irq during in_isr ignored, not latched.
REQ-028 Entry occurs on the first non-stalled cycle with pending set and no call, ret, iret or taken jump; it pushes incremented (current instruction completes), loads IRQ_VEC, sets in_isr, clears pending.
REQ-029 Entry with a full stack follows REQ-025: entry proceeds, ovf set.
REQ-030 iret clears in_isr; plain ret does not.
REQ-031 stall freezes addr, stack, sp, in_isr, pending; irq arriving during stall is still latched.
REQ-032 Address arithmetic wraps modulo 2^ADDR_W; no flag on wrap.
REQ-033 ovf and udf clear only on reset.

Reset
REQ-034 rst forces addr=RESET_VEC, sp=0, in_isr=0, pending=0, ovf=0, udf=0 immediately, independent of clk.
REQ-035 Stack storage contents need not reset; reset mid-call or mid-entry discards the operation.
REQ-036 First address change after reset release occurs on the first clk edge with rst low.

Structure
REQ-037 jump_t enum (4 bits: ALWAYS, Z, NZ, S, NS, O, NO, CY, NCY) lives in shared package cpu_pkg, reused by the decoder.
REQ-038 Return stack is sub-module ret_stack (params WIDTH, DEPTH; push, pop, data_in, data_out, sp, full, empty).
REQ-039 Next-address select and irq FSM (IDLE, PENDING, ISR) stay in flow_ctrl.

Verification
REQ-040 Reset at addr=0x37 asynchronously -> addr=0x00, sp=0, flags 0 before next edge.
REQ-041 addr=0xFF, no events -> next addr=0x00, no flag.
REQ-042 Nine calls to 0x10 with DEPTH=8 -> sp=8, ovf=1 after ninth, addr=0x10; nine rets -> eight correct returns, udf=1 on ninth.
REQ-043 irq pulse at addr=0x05 with taken jump to 0x20 -> addr=0x20, then 0xF0, in_isr=1; iret -> addr=0x21, in_isr=0.
REQ-044 irq during stall at addr=0x08 -> addr held; first unstalled cycle -> addr=0xF0, stack top=0x09.
REQ-045 jump_cond=NCY with flag_cy=1, jump_addr=0x40 at addr=0x12 -> addr=0x13; flag_cy=0 -> addr=0x40.
